// File: rtl/sdram_slot_arbiter.sv
// Slot arbiter for the shared SDRAM port: one command per 4-clock NES slot,
// loader bytes via a small FIFO, CPU/PPU conflicts resolved by a fairness flag.
module sdram_slot_arbiter #(
    parameter int ADDR_W     = 22,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        ce_phase,
    input  logic              downloading,
    input  logic              ld_wr,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_dout,
    input  logic              ppu_rd,
    input  logic [ADDR_W-1:0] ppu_addr,
    output logic [24:0]       sd_addr,
    output logic              sd_we,
    output logic [7:0]        sd_din,
    output logic              sd_oe_a,
    output logic              sd_oe_b,
    output logic              cpu_stall,
    output logic              ppu_stall,
    output logic              ld_busy,
    output logic              ld_overflow
);
    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic [1:0] {GNT_IDLE, GNT_LOAD, GNT_CPU, GNT_PPU} grant_t;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [7:0]        fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [IDX_W-1:0]  wr_idx, rd_idx;

    logic   boundary, fifo_empty, fifo_full, pop, push, drop, cpu_req;
    logic   ppu_owed, ppu_owed_n, ld_slot, ld_slot_n, dl_q;
    grant_t grant;

    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [7:0]        din_n;
    logic              we_n, oe_a_n, oe_b_n, cpu_stall_n, ppu_stall_n;

    assign wr_idx  = wr_ptr[IDX_W-1:0];
    assign rd_idx  = rd_ptr[IDX_W-1:0];
    assign sd_addr = {{(25-ADDR_W){1'b0}}, addr_q};
    // A loader write slot keeps the loader busy even after the FIFO runs dry.
    assign ld_busy = !fifo_empty || ld_slot;

    always_comb begin
        boundary   = (ce_phase == 2'd3);
        fifo_empty = (wr_ptr == rd_ptr);
        fifo_full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) && (wr_idx == rd_idx);
        pop        = boundary && !fifo_empty;
        push       = ld_wr && (!fifo_full || pop);
        drop       = ld_wr && fifo_full && !pop;
        cpu_req    = cpu_rd || cpu_wr;
    end

    // Loader traffic owns the port until the FIFO is empty and the download is over.
    always_comb begin
        grant = GNT_IDLE;
        if (!fifo_empty)
            grant = GNT_LOAD;
        else if (downloading)
            grant = GNT_IDLE;
        else if (cpu_req && !(ppu_rd && ppu_owed))
            grant = GNT_CPU;
        else if (ppu_rd)
            grant = GNT_PPU;
    end

    always_comb begin
        addr_n      = addr_q;
        din_n       = sd_din;
        we_n        = 1'b0;
        oe_a_n      = 1'b0;
        oe_b_n      = 1'b0;
        cpu_stall_n = 1'b0;
        ppu_stall_n = 1'b0;
        ppu_owed_n  = ppu_owed;
        ld_slot_n   = 1'b0;
        case (grant)
            GNT_LOAD: begin
                addr_n    = fifo_addr[rd_idx];
                din_n     = fifo_data[rd_idx];
                we_n      = 1'b1;
                ld_slot_n = 1'b1;
            end
            GNT_CPU: begin
                addr_n = cpu_addr;
                if (cpu_wr) begin
                    we_n  = 1'b1;
                    din_n = cpu_dout;
                end else begin
                    oe_a_n = 1'b1;
                end
                if (ppu_rd) begin
                    ppu_stall_n = 1'b1;
                    ppu_owed_n  = 1'b1;
                end
            end
            GNT_PPU: begin
                addr_n      = ppu_addr;
                oe_b_n      = 1'b1;
                cpu_stall_n = cpu_req;
                ppu_owed_n  = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_idx] <= ld_addr;
            fifo_data[wr_idx] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            addr_q      <= '0;
            sd_din      <= '0;
            sd_we       <= 1'b0;
            sd_oe_a     <= 1'b0;
            sd_oe_b     <= 1'b0;
            cpu_stall   <= 1'b0;
            ppu_stall   <= 1'b0;
            ppu_owed    <= 1'b0;
            ld_slot     <= 1'b0;
            ld_overflow <= 1'b0;
            dl_q        <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (boundary) begin
                addr_q    <= addr_n;
                sd_din    <= din_n;
                sd_we     <= we_n;
                sd_oe_a   <= oe_a_n;
                sd_oe_b   <= oe_b_n;
                cpu_stall <= cpu_stall_n;
                ppu_stall <= ppu_stall_n;
                ppu_owed  <= ppu_owed_n;
                ld_slot   <= ld_slot_n;
            end
            if (drop)
                ld_overflow <= 1'b1;
            else if (downloading && !dl_q)
                ld_overflow <= 1'b0;
            dl_q <= downloading;
        end
    end
endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Bench for sdram_slot_arbiter: vector table, directed loader/fairness/reset
// sequences, then random traffic against a queue-based slot model.
module tb_sdram_slot_arbiter;
    localparam int ADDR_W = 22;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [1:0]        ce_phase = 2'd0;
    logic              downloading = 1'b0;
    logic              ld_wr = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [7:0]        ld_data = '0;
    logic              cpu_rd = 1'b0, cpu_wr = 1'b0, ppu_rd = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0, ppu_addr = '0;
    logic [7:0]        cpu_dout = '0;
    logic [24:0]       sd_addr;
    logic              sd_we, sd_oe_a, sd_oe_b, cpu_stall, ppu_stall, ld_busy, ld_overflow;
    logic [7:0]        sd_din;

    int checks = 0;
    int errors = 0;
    bit adv = 1'b1;

    sdram_slot_arbiter #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .ce_phase(ce_phase), .downloading(downloading),
        .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .ppu_rd(ppu_rd), .ppu_addr(ppu_addr),
        .sd_addr(sd_addr), .sd_we(sd_we), .sd_din(sd_din), .sd_oe_a(sd_oe_a), .sd_oe_b(sd_oe_b),
        .cpu_stall(cpu_stall), .ppu_stall(ppu_stall), .ld_busy(ld_busy), .ld_overflow(ld_overflow)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [7:0]        d;
    } ent_t;
    ent_t        q[$];
    logic        m_owed = 0, m_we = 0, m_oea = 0, m_oeb = 0, m_cst = 0, m_pst = 0;
    logic        m_ld = 0, m_ovf = 0, m_dl = 0;
    logic [24:0] m_addr = '0;
    logic [7:0]  m_din = '0;

    task automatic model_step();
        ent_t e;
        logic cpu;
        if (!reset_n) begin
            q.delete();
            m_owed = 0; m_we = 0; m_oea = 0; m_oeb = 0; m_cst = 0; m_pst = 0;
            m_ld = 0; m_ovf = 0; m_dl = 0; m_addr = '0; m_din = '0;
        end else begin
            if (ce_phase == 2'd3) begin
                m_we = 0; m_oea = 0; m_oeb = 0; m_cst = 0; m_pst = 0; m_ld = 0;
                cpu = cpu_rd | cpu_wr;
                if (q.size() != 0) begin
                    e = q.pop_front();
                    m_we = 1; m_addr = {3'b000, e.a}; m_din = e.d; m_ld = 1;
                end else if (!downloading) begin
                    if (cpu && !(ppu_rd && m_owed)) begin
                        m_addr = {3'b000, cpu_addr};
                        if (cpu_wr) begin m_we = 1; m_din = cpu_dout; end
                        else m_oea = 1;
                        if (ppu_rd) begin m_pst = 1; m_owed = 1; end
                    end else if (ppu_rd) begin
                        m_addr = {3'b000, ppu_addr};
                        m_oeb = 1; m_cst = cpu; m_owed = 0;
                    end
                end
            end
            if (downloading && !m_dl) m_ovf = 0;
            if (ld_wr) begin
                if (q.size() < DEPTH) begin
                    e.a = ld_addr; e.d = ld_data;
                    q.push_back(e);
                end else m_ovf = 1;
            end
            m_dl = downloading;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        logic busy_exp;
        model_step();
        @(posedge clk);
        #1;
        busy_exp = (q.size() != 0) || m_ld;
        chk("model", {sd_we, sd_oe_a, sd_oe_b, cpu_stall, ppu_stall, ld_busy, ld_overflow, sd_din, sd_addr},
                     {m_we, m_oea, m_oeb, m_cst, m_pst, busy_exp, m_ovf, m_din, m_addr});
        if (adv) ce_phase = ce_phase + 2'd1;
    endtask

    task automatic run_to_boundary();
        int n = 0;
        while (ce_phase != 2'd3 && n < 8) begin tick(); n++; end
        tick();
    endtask

    task automatic align(input logic [1:0] p);
        int n = 0;
        while (ce_phase != p && n < 8) begin tick(); n++; end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic              crd, cwr, prd;
        logic [ADDR_W-1:0] caddr, paddr;
        logic [7:0]        cdout;
        logic              we, oea, oeb, cst, pst;
        logic [24:0]       addr;
        logic [7:0]        din;
    } vec_t;

    function automatic vec_t mk(input logic crd, cwr, prd, input logic [ADDR_W-1:0] caddr, paddr,
                                input logic [7:0] cdout, input logic we, oea, oeb, cst, pst,
                                input logic [24:0] addr, input logic [7:0] din);
        vec_t v;
        v.crd = crd; v.cwr = cwr; v.prd = prd; v.caddr = caddr; v.paddr = paddr; v.cdout = cdout;
        v.we = we; v.oea = oea; v.oeb = oeb; v.cst = cst; v.pst = pst; v.addr = addr; v.din = din;
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[10];
        vt[0] = mk(0,1,0, 22'h006000, 22'h000000, 8'h3C, 1,0,0,0,0, 25'h0006000, 8'h3C);
        vt[1] = mk(1,0,0, 22'h000123, 22'h000000, 8'h00, 0,1,0,0,0, 25'h0000123, 8'h3C);
        vt[2] = mk(0,0,1, 22'h000000, 22'h100200, 8'h00, 0,0,1,0,0, 25'h0100200, 8'h3C);
        vt[3] = mk(1,0,1, 22'h000400, 22'h100500, 8'h00, 0,1,0,0,1, 25'h0000400, 8'h3C);
        vt[4] = mk(1,0,1, 22'h000401, 22'h100501, 8'h00, 0,0,1,1,0, 25'h0100501, 8'h3C);
        vt[5] = mk(1,1,1, 22'h000777, 22'h100600, 8'h5A, 1,0,0,0,1, 25'h0000777, 8'h5A);
        vt[6] = mk(0,0,0, 22'h000000, 22'h000000, 8'h00, 0,0,0,0,0, 25'h0000777, 8'h5A);
        vt[7] = mk(0,0,1, 22'h000000, 22'h100700, 8'h00, 0,0,1,0,0, 25'h0100700, 8'h5A);
        vt[8] = mk(0,1,1, 22'h000800, 22'h100800, 8'h11, 1,0,0,0,1, 25'h0000800, 8'h11);
        vt[9] = mk(0,1,1, 22'h000900, 22'h100900, 8'h22, 0,0,1,1,0, 25'h0100900, 8'h11);

        // reset
        reset_n = 0;
        repeat (3) tick();
        reset_n = 1;
        chk("reset_state", {sd_we, sd_oe_a, sd_oe_b, cpu_stall, ppu_stall, ld_busy, ld_overflow, sd_din, sd_addr}, 0);

        // arbitration vectors, one slot each
        for (int i = 0; i < 10; i++) begin
            cpu_rd = vt[i].crd; cpu_wr = vt[i].cwr; ppu_rd = vt[i].prd;
            cpu_addr = vt[i].caddr; ppu_addr = vt[i].paddr; cpu_dout = vt[i].cdout;
            run_to_boundary();
            chk($sformatf("vec%0d", i), {sd_we, sd_oe_a, sd_oe_b, cpu_stall, ppu_stall, sd_addr, sd_din},
                {vt[i].we, vt[i].oea, vt[i].oeb, vt[i].cst, vt[i].pst, vt[i].addr, vt[i].din});
        end

        // fairness: both held, fairness flag is clear here
        cpu_rd = 1; cpu_wr = 0; ppu_rd = 1; cpu_addr = 22'h000AAA; ppu_addr = 22'h100BBB;
        for (int i = 0; i < 8; i++) begin
            run_to_boundary();
            chk($sformatf("fair%0d", i), {sd_oe_a, sd_oe_b, cpu_stall, ppu_stall},
                (i % 2 == 0) ? 4'b1001 : 4'b0110);
        end
        cpu_rd = 0; ppu_rd = 0;
        run_to_boundary();

        // single loader byte
        downloading = 1;
        align(2'd0);
        ld_wr = 1; ld_addr = 22'h000010; ld_data = 8'hA5;
        tick();
        ld_wr = 0;
        repeat (3) tick();
        chk("single_slot", {sd_we, sd_addr, sd_din, ld_busy}, {1'b1, 25'h0000010, 8'hA5, 1'b1});
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("single_hold", {sd_we, sd_addr, sd_din}, {1'b1, 25'h0000010, 8'hA5});
        end
        tick();
        chk("single_done", {sd_we, ld_busy}, 2'b00);

        // overflow: 6 back-to-back bytes, one pop in between
        align(2'd0);
        for (int i = 0; i < 6; i++) begin
            ld_wr = 1; ld_addr = 22'h000020 + ADDR_W'(i); ld_data = 8'h80 + 8'(i);
            tick();
            if (i == 3) chk("ovf_slot0", {sd_we, sd_addr}, {1'b1, 25'h0000020});
        end
        ld_wr = 0;
        chk("ovf_flag", ld_overflow, 1'b1);
        for (int k = 1; k < 5; k++) begin
            run_to_boundary();
            chk($sformatf("ovf_slot%0d", k), {sd_we, sd_addr, sd_din},
                {1'b1, 25'h0000020 + 25'(k), 8'h80 + 8'(k)});
        end
        run_to_boundary();
        chk("ovf_drained", {sd_we, ld_busy, ld_overflow}, 3'b001);
        downloading = 0;
        tick();
        chk("ovf_sticky", ld_overflow, 1'b1);
        downloading = 1;
        tick();
        chk("ovf_clear_on_rise", ld_overflow, 1'b0);

        // drain after download ends with a CPU read waiting
        align(2'd0);
        for (int i = 0; i < 3; i++) begin
            ld_wr = 1; ld_addr = 22'h000040 + ADDR_W'(i); ld_data = 8'h40 + 8'(i);
            tick();
        end
        ld_wr = 0; downloading = 0; cpu_rd = 1; cpu_addr = 22'h001234;
        for (int k = 0; k < 3; k++) begin
            run_to_boundary();
            chk($sformatf("drain%0d", k), {sd_we, sd_oe_a, cpu_stall, sd_addr},
                {1'b1, 1'b0, 1'b0, 25'h0000040 + 25'(k)});
        end
        run_to_boundary();
        chk("drain_cpu", {sd_we, sd_oe_a, cpu_stall, sd_addr}, {1'b0, 1'b1, 1'b0, 25'h0001234});
        cpu_rd = 0;

        // reset in the middle of a loader write slot with 2 bytes queued
        downloading = 1;
        align(2'd0);
        for (int i = 0; i < 3; i++) begin
            ld_wr = 1; ld_addr = 22'h000050 + ADDR_W'(i); ld_data = 8'h50 + 8'(i);
            tick();
        end
        ld_wr = 0;
        tick();
        chk("rst_pre", {sd_we, sd_addr, ld_busy}, {1'b1, 25'h0000050, 1'b1});
        tick();
        reset_n = 0;
        tick();
        chk("rst_mid", {sd_we, sd_oe_a, sd_oe_b, cpu_stall, ppu_stall, ld_busy, ld_overflow, sd_din, sd_addr}, 0);
        reset_n = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("rst_no_stale", {sd_we, ld_busy}, 2'b00);
        end

        // random traffic against the model, including stalled phases and resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 80 == 0) downloading = ~downloading;
            ld_wr    = downloading ? ($urandom % 3 == 0) : ($urandom % 25 == 0);
            ld_addr  = ADDR_W'($urandom);
            ld_data  = 8'($urandom);
            cpu_rd   = ($urandom % 3 == 0);
            cpu_wr   = ($urandom % 6 == 0);
            ppu_rd   = ($urandom % 2 == 0);
            cpu_addr = ADDR_W'($urandom);
            ppu_addr = ADDR_W'($urandom);
            cpu_dout = 8'($urandom);
            reset_n  = ($urandom % 400 != 0);
            adv      = ($urandom % 8 != 0);
            tick();
        end
        adv = 1; reset_n = 1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
